// File: rtl/motion_vectors_decoder_if.sv
// Bus between the flush-buffer window, the motion-vector decoder and the predictor store.
// The master side drives configuration and bit window; the slave side is the decoder.
interface motion_vectors_decoder_if #(
  parameter int MV_W  = 16,
  parameter int WIN_W = 16
);
  logic              start;
  logic              mv_count;
  logic              field_sel_en;
  logic              dmv;
  logic              mvscale;
  logic [3:0]        f_code_h;
  logic [3:0]        f_code_v;
  logic [4*MV_W-1:0] pmv_in;
  logic [WIN_W-1:0]  win;
  logic              win_valid;
  logic              adv_valid;
  logic [4:0]        adv_n;
  logic [4*MV_W-1:0] pmv_out;
  logic [1:0]        mvfs_out;
  logic [3:0]        dmvec_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mv_count, field_sel_en, dmv, mvscale, f_code_h, f_code_v,
           pmv_in, win, win_valid,
    input  adv_valid, adv_n, pmv_out, mvfs_out, dmvec_out, busy, done, err
  );

  modport slave (
    input  start, mv_count, field_sel_en, dmv, mvscale, f_code_h, f_code_v,
           pmv_in, win, win_valid,
    output adv_valid, adv_n, pmv_out, mvfs_out, dmvec_out, busy, done, err
  );
endinterface

// File: rtl/motion_vectors_decoder.sv
// Parses one motion_vectors(s) structure from a bit window and updates the PMV predictors.
// Bits are consumed combinationally (adv_valid/adv_n) so upstream shifts on the same edge.
module motion_vectors_decoder #(
  parameter int MV_W  = 16,
  parameter int WIN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  motion_vectors_decoder_if.slave  bus
);

  localparam int EW = MV_W + 2;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_MVFS  = 4'd1;
  localparam logic [3:0] S_HCODE = 4'd2;
  localparam logic [3:0] S_HRES  = 4'd3;
  localparam logic [3:0] S_HDMV  = 4'd4;
  localparam logic [3:0] S_VCODE = 4'd5;
  localparam logic [3:0] S_VRES  = 4'd6;
  localparam logic [3:0] S_VDMV  = 4'd7;
  localparam logic [3:0] S_UPD   = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;

  logic [3:0]               r_state;
  logic                     r_vec;
  logic                     r_cfg_cnt;
  logic                     r_cfg_fs;
  logic                     r_cfg_dmv;
  logic                     r_cfg_scale;
  logic [3:0]               r_rsize_h;
  logic [3:0]               r_rsize_v;
  logic [4*MV_W-1:0]        r_pmv_in;
  logic signed [MV_W-1:0]   r_pmv [4];
  logic [4:0]               r_mag_h;
  logic [4:0]               r_mag_v;
  logic                     r_neg_h;
  logic                     r_neg_v;
  logic [7:0]               r_res_h;
  logic [7:0]               r_res_v;
  logic [1:0]               r_fs;
  logic [1:0]               r_dmv_h;
  logic [1:0]               r_dmv_v;
  logic                     r_bad;
  logic [4*MV_W-1:0]        r_pmv_out;
  logic [1:0]               r_mvfs_out;
  logic [3:0]               r_dmvec_out;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic [9:0]               w_pre;
  logic [10:0]              w_top11;
  logic [7:0]               w_top8;
  logic                     w_msb;
  logic                     w_vlc_ok;
  logic [4:0]               w_mag;
  logic [3:0]               w_pre_len;
  logic                     w_sign;
  logic [4:0]               w_code_len;
  logic [3:0]               w_rsize;
  logic [7:0]               w_res;
  logic [1:0]               w_dmv_val;
  logic [4:0]               w_dmv_len;
  logic                     w_adv_valid;
  logic [4:0]               w_adv_n;
  logic signed [MV_W-1:0]   w_new_h;
  logic signed [MV_W-1:0]   w_new_v;

  function automatic logic [3:0] f_rsize(input logic [3:0] fc);
    if (fc == 4'd0)      return 4'd0;
    else if (fc > 4'd9)  return 4'd8;
    else                 return fc - 4'd1;
  endfunction

  // Predictor update with f_code-dependent wrap into [-16f, 16f-1]; mvscale halves/doubles.
  function automatic logic signed [MV_W-1:0] f_mv_upd(
    input logic signed [MV_W-1:0] pred,
    input logic [4:0]             mag,
    input logic                   neg,
    input logic [7:0]             res,
    input logic [3:0]             rsize,
    input logic                   scale
  );
    logic signed [EW-1:0] p;
    logic signed [EW-1:0] delta;
    logic signed [EW-1:0] f;
    logic signed [EW-1:0] range;
    logic signed [EW-1:0] high;
    logic signed [EW-1:0] low;
    logic [EW-1:0]        d_u;
    f     = EW'(1) <<< rsize;
    range = f <<< 5;
    high  = (f <<< 4) - EW'(1);
    low   = -(f <<< 4);
    p     = {{2{pred[MV_W-1]}}, pred};
    if (scale) p = p >>> 1;
    d_u   = ({{(EW-5){1'b0}}, mag - 5'd1} << rsize) + {{(EW-8){1'b0}}, res} + EW'(1);
    if (mag == 5'd0)  delta = '0;
    else if (neg)     delta = -$signed(d_u);
    else              delta = $signed(d_u);
    p = p + delta;
    if (p > high) p = p - range;
    if (p < low)  p = p + range;
    if (scale) p = p <<< 1;
    return p[MV_W-1:0];
  endfunction

  assign w_pre   = bus.win[WIN_W-1 -: 10];
  assign w_top11 = bus.win[WIN_W-1 -: 11];
  assign w_top8  = bus.win[WIN_W-1 -: 8];
  assign w_msb   = bus.win[WIN_W-1];

  // motion_code magnitude prefix; the sign bit follows it for nonzero codes
  always_comb begin
    w_vlc_ok  = 1'b1;
    w_mag     = 5'd0;
    w_pre_len = 4'd1;
    casez (w_pre)
      10'b1?????????: begin w_mag = 5'd0;  w_pre_len = 4'd1;  end
      10'b01????????: begin w_mag = 5'd1;  w_pre_len = 4'd2;  end
      10'b001???????: begin w_mag = 5'd2;  w_pre_len = 4'd3;  end
      10'b0001??????: begin w_mag = 5'd3;  w_pre_len = 4'd4;  end
      10'b000011????: begin w_mag = 5'd4;  w_pre_len = 4'd6;  end
      10'b0000101???: begin w_mag = 5'd5;  w_pre_len = 4'd7;  end
      10'b0000100???: begin w_mag = 5'd6;  w_pre_len = 4'd7;  end
      10'b0000011???: begin w_mag = 5'd7;  w_pre_len = 4'd7;  end
      10'b000001011?: begin w_mag = 5'd8;  w_pre_len = 4'd9;  end
      10'b000001010?: begin w_mag = 5'd9;  w_pre_len = 4'd9;  end
      10'b000001001?: begin w_mag = 5'd10; w_pre_len = 4'd9;  end
      10'b0000010001: begin w_mag = 5'd11; w_pre_len = 4'd10; end
      10'b0000010000: begin w_mag = 5'd12; w_pre_len = 4'd10; end
      10'b0000001111: begin w_mag = 5'd13; w_pre_len = 4'd10; end
      10'b0000001110: begin w_mag = 5'd14; w_pre_len = 4'd10; end
      10'b0000001101: begin w_mag = 5'd15; w_pre_len = 4'd10; end
      10'b0000001100: begin w_mag = 5'd16; w_pre_len = 4'd10; end
      default:        w_vlc_ok = 1'b0;
    endcase
  end

  assign w_sign     = w_top11[4'd10 - w_pre_len];
  assign w_code_len = (w_mag == 5'd0) ? 5'd1 : {1'b0, w_pre_len} + 5'd1;
  assign w_rsize    = (r_state == S_HRES) ? r_rsize_h : r_rsize_v;
  assign w_res      = w_top8 >> (4'd8 - w_rsize);
  assign w_dmv_val  = w_msb ? (bus.win[WIN_W-2] ? 2'b11 : 2'b01) : 2'b00;
  assign w_dmv_len  = w_msb ? 5'd2 : 5'd1;

  always_comb begin
    w_adv_valid = 1'b0;
    w_adv_n     = 5'd0;
    if (!rst && bus.win_valid) begin
      case (r_state)
        S_MVFS: begin
          w_adv_valid = 1'b1;
          w_adv_n     = 5'd1;
        end
        S_HCODE, S_VCODE: begin
          w_adv_valid = w_vlc_ok;
          w_adv_n     = w_vlc_ok ? w_code_len : 5'd0;
        end
        S_HRES, S_VRES: begin
          w_adv_valid = 1'b1;
          w_adv_n     = {1'b0, w_rsize};
        end
        S_HDMV, S_VDMV: begin
          w_adv_valid = 1'b1;
          w_adv_n     = w_dmv_len;
        end
        default: ;
      endcase
    end
  end

  assign w_new_h = f_mv_upd(r_pmv[{r_vec, 1'b0}], r_mag_h, r_neg_h, r_res_h, r_rsize_h, 1'b0);
  assign w_new_v = f_mv_upd(r_pmv[{r_vec, 1'b1}], r_mag_v, r_neg_v, r_res_v, r_rsize_v, r_cfg_scale);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vec       <= 1'b0;
      r_cfg_cnt   <= 1'b0;
      r_cfg_fs    <= 1'b0;
      r_cfg_dmv   <= 1'b0;
      r_cfg_scale <= 1'b0;
      r_rsize_h   <= 4'd0;
      r_rsize_v   <= 4'd0;
      r_pmv_in    <= '0;
      for (int k = 0; k < 4; k++) r_pmv[k] <= '0;
      r_mag_h     <= 5'd0;
      r_mag_v     <= 5'd0;
      r_neg_h     <= 1'b0;
      r_neg_v     <= 1'b0;
      r_res_h     <= 8'd0;
      r_res_v     <= 8'd0;
      r_fs        <= 2'b00;
      r_dmv_h     <= 2'b00;
      r_dmv_v     <= 2'b00;
      r_bad       <= 1'b0;
      r_pmv_out   <= '0;
      r_mvfs_out  <= 2'b00;
      r_dmvec_out <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_vec       <= 1'b0;
            r_cfg_cnt   <= bus.mv_count;
            r_cfg_fs    <= bus.field_sel_en;
            r_cfg_dmv   <= bus.dmv;
            r_cfg_scale <= bus.mvscale;
            r_rsize_h   <= f_rsize(bus.f_code_h);
            r_rsize_v   <= f_rsize(bus.f_code_v);
            r_pmv_in    <= bus.pmv_in;
            for (int k = 0; k < 4; k++) r_pmv[k] <= bus.pmv_in[k*MV_W +: MV_W];
            r_fs        <= 2'b00;
            r_dmv_h     <= 2'b00;
            r_dmv_v     <= 2'b00;
            r_bad       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= bus.field_sel_en ? S_MVFS : S_HCODE;
          end
        end
        S_MVFS: begin
          if (bus.win_valid) begin
            r_fs[r_vec] <= w_msb;
            r_state     <= S_HCODE;
          end
        end
        S_HCODE: begin
          if (bus.win_valid) begin
            if (!w_vlc_ok) begin
              r_bad   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_mag_h <= w_mag;
              r_neg_h <= (w_mag != 5'd0) && w_sign;
              r_res_h <= 8'd0;
              if (w_mag != 5'd0 && r_rsize_h != 4'd0) r_state <= S_HRES;
              else if (r_cfg_dmv)                     r_state <= S_HDMV;
              else                                    r_state <= S_VCODE;
            end
          end
        end
        S_HRES: begin
          if (bus.win_valid) begin
            r_res_h <= w_res;
            r_state <= r_cfg_dmv ? S_HDMV : S_VCODE;
          end
        end
        S_HDMV: begin
          if (bus.win_valid) begin
            r_dmv_h <= w_dmv_val;
            r_state <= S_VCODE;
          end
        end
        S_VCODE: begin
          if (bus.win_valid) begin
            if (!w_vlc_ok) begin
              r_bad   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_mag_v <= w_mag;
              r_neg_v <= (w_mag != 5'd0) && w_sign;
              r_res_v <= 8'd0;
              if (w_mag != 5'd0 && r_rsize_v != 4'd0) r_state <= S_VRES;
              else if (r_cfg_dmv)                     r_state <= S_VDMV;
              else                                    r_state <= S_UPD;
            end
          end
        end
        S_VRES: begin
          if (bus.win_valid) begin
            r_res_v <= w_res;
            r_state <= r_cfg_dmv ? S_VDMV : S_UPD;
          end
        end
        S_VDMV: begin
          if (bus.win_valid) begin
            r_dmv_v <= w_dmv_val;
            r_state <= S_UPD;
          end
        end
        S_UPD: begin
          r_pmv[{r_vec, 1'b0}] <= w_new_h;
          r_pmv[{r_vec, 1'b1}] <= w_new_v;
          if (!r_vec && r_cfg_cnt) begin
            r_vec   <= 1'b1;
            r_state <= r_cfg_fs ? S_MVFS : S_HCODE;
          end else begin
            // single-vector macroblocks mirror r0 into the r1 predictor and field select
            if (!r_vec) begin
              r_pmv[2] <= w_new_h;
              r_pmv[3] <= w_new_v;
              r_fs[1]  <= r_fs[0];
            end
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          for (int k = 0; k < 4; k++)
            r_pmv_out[k*MV_W +: MV_W] <= r_bad ? r_pmv_in[k*MV_W +: MV_W] : r_pmv[k];
          r_mvfs_out  <= r_fs;
          r_dmvec_out <= {r_dmv_v, r_dmv_h};
          r_err       <= r_bad;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.adv_valid = w_adv_valid;
  assign bus.adv_n     = w_adv_n;
  assign bus.pmv_out   = r_pmv_out;
  assign bus.mvfs_out  = r_mvfs_out;
  assign bus.dmvec_out = r_dmvec_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_motion_vectors_decoder.sv
// Scoreboard bench for motion_vectors_decoder: a bit-stream model feeds the window,
// directed transactions push expected adv_n and results, a negedge monitor compares.
module tb_motion_vectors_decoder;
  localparam int MV_W  = 16;
  localparam int WIN_W = 16;

  typedef struct packed {
    logic [63:0] pmv;
    logic [1:0]  fs;
    logic [3:0]  dv;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  motion_vectors_decoder_if #(.MV_W(MV_W), .WIN_W(WIN_W)) bus ();
  motion_vectors_decoder #(.MV_W(MV_W), .WIN_W(WIN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  bit   stream [0:4095];
  int   ptr = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q [$];
  int   adv_q [$];

  // upstream flush buffer: shifts by adv_n on the edge where adv_valid is high
  always @(posedge clk) if (bus.adv_valid) ptr <= ptr + int'(bus.adv_n);

  always_comb begin
    bus.win = '0;
    for (int i = 0; i < WIN_W; i++) bus.win[WIN_W-1-i] = stream[(ptr + i) % 4096];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {a[15:0], b[15:0], c[15:0], d[15:0]};
  endfunction

  task automatic adv(input int n);
    adv_q.push_back(n);
  endtask

  task automatic expect_res(input logic [63:0] p, input logic [1:0] f, input logic [3:0] d, input logic e);
    res_t r;
    r.pmv = p; r.fs = f; r.dv = d; r.err = e;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (bus.adv_valid) begin
      n_cmp++;
      if (adv_q.size() == 0) begin
        n_bad++;
        $display("FAIL adv_unexpected: got adv_n=%0d expected no advance", bus.adv_n);
      end else begin
        int e;
        e = adv_q.pop_front();
        n_cmp--;
        chk("adv_n", 64'(bus.adv_n), 64'(e));
      end
    end
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done_unexpected: got done=1 expected no result");
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("pmv_out",   bus.pmv_out,          r.pmv);
        chk("mvfs_out",  64'(bus.mvfs_out),    64'(r.fs));
        chk("dmvec_out", 64'(bus.dmvec_out),   64'(r.dv));
        chk("err",       64'(bus.err),         64'(r.err));
      end
    end
  end

  task automatic tx(input logic cnt, input logic fsel, input logic dm, input logic sc,
                    input logic [3:0] fh, input logic [3:0] fv, input logic [63:0] pin,
                    input string s);
    for (int i = 0; i < s.len(); i++) stream[(ptr + i) % 4096] = (s[i] == "1");
    for (int i = s.len(); i < s.len() + 32; i++) stream[(ptr + i) % 4096] = 1'b0;
    @(posedge clk); #1;
    bus.mv_count = cnt; bus.field_sel_en = fsel; bus.dmv = dm; bus.mvscale = sc;
    bus.f_code_h = fh; bus.f_code_v = fv; bus.pmv_in = pin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!bus.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got no done expected done within 300 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_adv(input string name);
    int k;
    k = 0;
    while (!bus.adv_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got no adv expected adv within 50 cycles", name);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.mv_count = 1'b0; bus.field_sel_en = 1'b0; bus.dmv = 1'b0;
    bus.mvscale = 1'b0; bus.f_code_h = 4'd1; bus.f_code_v = 4'd1; bus.pmv_in = '0;
    bus.win_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_adv_valid", 64'(bus.adv_valid), 64'd0);
    chk("rst_adv_n",     64'(bus.adv_n),     64'd0);
    chk("rst_pmv_out",   bus.pmv_out,        64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_done",      64'(bus.done),      64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);

    // zero codes, single vector
    adv(1); adv(1);
    expect_res(pk(0, 0, 0, 0), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd1, 4'd1, pk(0, 0, 0, 0), "11");
    wait_done("t1");

    // +2 with 1-bit residual, r1 overwritten by copy of r0
    adv(4); adv(1); adv(1);
    expect_res(pk(7, 14, 7, 14), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd2, 4'd1, pk(-200, 100, 7, 10), "001011");
    wait_done("t2");

    // wrap at high and low bounds
    adv(3); adv(1);
    expect_res(pk(0, -16, 0, -16), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd1, 4'd1, pk(0, 0, 0, 15), "0101");
    wait_done("t3a");
    adv(3); adv(1);
    expect_res(pk(0, 15, 0, 15), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd1, 4'd1, pk(0, 0, 0, -16), "0111");
    wait_done("t3b");

    // mvscale on vertical
    adv(1); adv(3);
    expect_res(pk(4, 3, 4, 3), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 1, 4'd1, 4'd1, pk(0, 0, 6, 3), "1011");
    wait_done("t4");
    adv(1); adv(1);
    expect_res(pk(-8, 0, -8, 0), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 1, 4'd1, 4'd1, pk(0, 0, -7, 0), "11");
    wait_done("t4b");

    // -5 with 2-bit residual wrapping up past low
    adv(8); adv(2); adv(1);
    expect_res(pk(0, 50, 0, 50), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd3, 4'd1, pk(0, 0, 0, -60), "00001011011");
    wait_done("t_neg5");

    // two vectors with field select and dual-prime, plus an ignored start while busy
    adv(1); adv(1); adv(1); adv(1); adv(1);
    adv(1); adv(1); adv(2); adv(1); adv(1);
    expect_res(pk(-3, 9, 2, -1), 2'b10, 4'b0011, 1'b0);
    tx(1, 1, 1, 0, 4'd1, 4'd1, pk(-3, 9, 2, -1), "01010111110");
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1; bus.mv_count = 1'b0; bus.dmv = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("t5");

    // window stall during H_RES
    adv(3); adv(2); adv(1);
    expect_res(pk(-5, 4, -5, 4), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd3, 4'd1, pk(0, 0, -5, 0), "010111");
    wait_adv("t6_stall");
    @(posedge clk); #1 bus.win_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_adv_valid", 64'(bus.adv_valid), 64'd0);
      chk("stall_busy",      64'(bus.busy),      64'd1);
    end
    @(posedge clk); #1 bus.win_valid = 1'b1;
    wait_done("t6");

    // invalid motion_code
    expect_res(pk(1, 2, 3, 4), 2'b00, 4'h0, 1'b1);
    tx(0, 0, 0, 0, 4'd1, 4'd1, pk(1, 2, 3, 4), "00000000001");
    wait_done("t_err");
    repeat (2) @(negedge clk);
    chk("err_held", 64'(bus.err), 64'd1);

    // reset while in V_CODE
    adv(1);
    tx(0, 0, 0, 0, 4'd1, 4'd1, pk(0, 0, 0, 0), "11");
    wait_adv("t_rst");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_adv_valid", 64'(bus.adv_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",      64'(bus.busy),      64'd0);
    chk("rst_mid_adv_valid2", 64'(bus.adv_valid), 64'd0);
    chk("rst_mid_pmv_out",   bus.pmv_out,        64'd0);
    chk("rst_mid_err",       64'(bus.err),       64'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done",   64'(bus.done),      64'd0);

    // recovery after reset
    adv(1); adv(1);
    expect_res(pk(5, -6, 5, -6), 2'b00, 4'h0, 1'b0);
    tx(0, 0, 0, 0, 4'd1, 4'd1, pk(0, 0, 5, -6), "11");
    wait_done("t_recover");

    repeat (4) @(negedge clk);
    chk("adv_q_drained", 64'(adv_q.size()), 64'd0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
